// File: rtl/axi_lite_reg_slave.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_reg_slave
// Purpose : AXI4-Lite subordinate exposing C_NUM_REGS 32-bit R/W registers.
//           Optional out-of-range SLVERR decode via macro AXIL_REG_SLVERR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module axi_lite_reg_slave #(
    parameter int C_NUM_REGS         = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [32*C_NUM_REGS-1:0]      reg_out,
    output logic [C_NUM_REGS-1:0]         reg_wr
);

    localparam int IW = $clog2(C_NUM_REGS);
`ifdef AXIL_REG_SLVERR_EN
    localparam int DW = IW + 1;
`else
    localparam int DW = IW;
`endif
    localparam logic [DW:0] NUM_W  = C_NUM_REGS[DW:0];
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic          aw_held;
    logic          w_held;
    logic [DW-1:0] aw_idx;
    logic [31:0]   w_data;
    logic [3:0]    w_strb;
    logic [DW-1:0] rd_idx;
    logic [IW-1:0] wr_slot;
    logic [IW-1:0] rd_slot;
    logic          wr_hit;
    logic          rd_hit;
    logic          unused_ok;

    // Folds an index that overshoots a non-power-of-two bank back into range.
    function automatic logic [IW-1:0] slot(input logic [DW-1:0] idx);
        if ({1'b0, idx} >= NUM_W)
            return idx[IW-1:0] - NUM_W[IW-1:0];
        return idx[IW-1:0];
    endfunction

    assign rd_idx  = s_axi_araddr[2 +: DW];
    assign wr_slot = slot(aw_idx);
    assign rd_slot = slot(rd_idx);

`ifdef AXIL_REG_SLVERR_EN
    assign wr_hit = ({1'b0, aw_idx} < NUM_W);
    assign rd_hit = ({1'b0, rd_idx} < NUM_W);
`else
    assign wr_hit = 1'b1;
    assign rd_hit = 1'b1;
`endif

    assign s_axi_awready = !aw_held && !s_axi_bvalid;
    assign s_axi_wready  = !w_held && !s_axi_bvalid;
    assign s_axi_arready = !s_axi_rvalid;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr, s_axi_araddr};

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx       <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= OKAY;
            reg_wr       <= '0;
            reg_out      <= '0;
        end else begin
            reg_wr <= '0;
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi_awaddr[2 +: DW];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            // Both halves held implies bvalid is low, so no B handshake can collide here.
            if (aw_held && w_held) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi_bvalid <= 1'b1;
                if (wr_hit) begin
                    for (int b = 0; b < 4; b++) begin
                        if (w_strb[b])
                            reg_out[32*int'(wr_slot) + 8*b +: 8] <= w_data[8*b +: 8];
                    end
                    reg_wr[wr_slot] <= 1'b1;
                    s_axi_bresp     <= OKAY;
                end else begin
                    s_axi_bresp <= SLVERR;
                end
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            s_axi_rvalid <= 1'b1;
            if (rd_hit) begin
                s_axi_rdata <= reg_out[32*int'(rd_slot) +: 32];
                s_axi_rresp <= OKAY;
            end else begin
                s_axi_rdata <= '0;
                s_axi_rresp <= SLVERR;
            end
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_axi_lite_reg_slave
// Purpose : Directed self-checking bench for axi_lite_reg_slave (C_NUM_REGS=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_lite_reg_slave;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [31:0]    awaddr = '0, araddr = '0, wdata = '0;
    logic [2:0]     awprot = '0, arprot = '0;
    logic [3:0]     wstrb = '0;
    logic           awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic           awready, wready, bvalid, arready, rvalid;
    logic [1:0]     bresp, rresp;
    logic [31:0]    rdata;
    logic [32*N-1:0] reg_out;
    logic [N-1:0]   reg_wr;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [N];
    logic [31:0] d;
    logic [1:0]  r;
    logic [N-1:0] w;

    always #5 clk = ~clk;

    axi_lite_reg_slave #(.C_NUM_REGS(N), .C_S_AXI_ADDR_WIDTH(32)) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_out(reg_out), .reg_wr(reg_wr)
    );

    task automatic chk(input string tag, input logic ok, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [32*N-1:0] model_flat();
        logic [32*N-1:0] f;
        for (int k = 0; k < N; k++) f[32*k +: 32] = model[k];
        return f;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [N-1:0] wr);
        int n;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        n = 0;
        while (!(awready && wready) && n < 20) begin tick(); n++; end
        chk("wr_accept", (awready && wready) === 1'b1, (awready && wready), 1'b1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk("wr_bvalid", bvalid === 1'b1, bvalid, 1'b1);
        resp = bresp; wr = reg_wr;
        bready = 1'b1; tick(); bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        while (!arready && n < 20) begin tick(); n++; end
        chk("rd_accept", arready === 1'b1, arready, 1'b1);
        tick();
        arvalid = 1'b0;
        chk("rd_latency", rvalid === 1'b1, rvalid, 1'b1);
        data = rdata; resp = rresp;
        rready = 1'b1; tick(); rready = 1'b0;
        chk("rd_release", rvalid === 1'b0, rvalid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) model[k] = 32'h0;
        tick(); tick();
        chk("rst_awready", awready === 1'b1, awready, 1'b1);
        chk("rst_wready", wready === 1'b1, wready, 1'b1);
        chk("rst_arready", arready === 1'b1, arready, 1'b1);
        chk("rst_bvalid", bvalid === 1'b0, bvalid, 1'b0);
        chk("rst_rvalid", rvalid === 1'b0, rvalid, 1'b0);
        chk("rst_rdata", rdata === 32'h0, rdata, 32'h0);
        chk("rst_reg_wr", reg_wr === 8'h00, reg_wr, 8'h00);
        chk("rst_regs", reg_out === 256'h0, reg_out, 256'h0);
        rst = 1'b0;
        tick();

        wdata = 32'h01020304; wstrb = 4'hF; wvalid = 1'b1; tick();
        wvalid = 1'b0;
        chk("t1_wready_held", wready === 1'b0, wready, 1'b0);
        chk("t1_awready_open", awready === 1'b1, awready, 1'b1);
        awaddr = 32'h43C00004; awvalid = 1'b1; tick();
        awvalid = 1'b0;
        chk("t1_no_b_yet", bvalid === 1'b0, bvalid, 1'b0);
        tick();
        chk("t1_bvalid", bvalid === 1'b1, bvalid, 1'b1);
        chk("t1_bresp", bresp === 2'b00, bresp, 2'b00);
        chk("t1_reg_wr", reg_wr === 8'h02, reg_wr, 8'h02);
        chk("t1_reg1", reg_out[63:32] === 32'h01020304, reg_out[63:32], 32'h01020304);
        model[1] = 32'h01020304;
        bready = 1'b1; tick(); bready = 1'b0;
        chk("t1_b_done", bvalid === 1'b0, bvalid, 1'b0);
        chk("t1_pulse_end", reg_wr === 8'h00, reg_wr, 8'h00);

        awaddr = 32'h43C00000; awvalid = 1'b1; tick();
        awvalid = 1'b0;
        chk("t2_awready_held", awready === 1'b0, awready, 1'b0);
        chk("t2_wready_wait0", wready === 1'b1, wready, 1'b1);
        tick();
        chk("t2_wready_wait1", wready === 1'b1, wready, 1'b1);
        wdata = 32'h00000003; wstrb = 4'hF; wvalid = 1'b1; tick();
        wvalid = 1'b0;
        chk("t2_no_b_yet", bvalid === 1'b0, bvalid, 1'b0);
        tick();
        chk("t2_bvalid", bvalid === 1'b1, bvalid, 1'b1);
        chk("t2_reg_wr", reg_wr === 8'h01, reg_wr, 8'h01);
        model[0] = 32'h00000003;
        bready = 1'b1; tick(); bready = 1'b0;
        axi_read(32'h43C00000, d, r);
        chk("t2_rdata", d === 32'h00000003, d, 32'h00000003);
        chk("t2_rresp", r === 2'b00, r, 2'b00);

        axi_write(32'h43C00008, 32'h05060708, 4'hF, r, w);
        chk("t3_bresp", r === 2'b00, r, 2'b00);
        chk("t3_reg_wr", w === 8'h04, w, 8'h04);
        axi_write(32'h43C00008, 32'hFFFFFFFF, 4'h5, r, w);
        model[2] = 32'h05FF07FF;
        axi_read(32'h43C00008, d, r);
        chk("t3_strb_rdata", d === 32'h05FF07FF, d, 32'h05FF07FF);

        awaddr = 32'h43C00004; wdata = 32'h00000055; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h43C00004; arvalid = 1'b1;
        chk("t4_arready", arready === 1'b1, arready, 1'b1);
        tick();
        arvalid = 1'b0;
        chk("t4_rvalid", rvalid === 1'b1, rvalid, 1'b1);
        chk("t4_pre_write", rdata === 32'h01020304, rdata, 32'h01020304);
        chk("t4_bvalid", bvalid === 1'b1, bvalid, 1'b1);
        chk("t4_reg1_new", reg_out[63:32] === 32'h00000055, reg_out[63:32], 32'h00000055);
        model[1] = 32'h00000055;
        bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
        axi_read(32'h43C00004, d, r);
        chk("t4_post_write", d === 32'h00000055, d, 32'h00000055);

        awaddr = 32'h43C0000C; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        chk("t5_bvalid", bvalid === 1'b1, bvalid, 1'b1);
        chk("t5_reg_wr", reg_wr === 8'h08, reg_wr, 8'h08);
        awaddr = 32'h43C00010; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_bvalid", bvalid === 1'b1, bvalid, 1'b1);
            chk("t5_hold_awready", awready === 1'b0, awready, 1'b0);
            chk("t5_hold_wready", wready === 1'b0, wready, 1'b0);
            tick();
        end
        bready = 1'b1;
        chk("t5_awready_pre_b", awready === 1'b0, awready, 1'b0);
        tick();
        bready = 1'b0;
        chk("t5_b_done", bvalid === 1'b0, bvalid, 1'b0);
        chk("t5_awready_reopen", awready === 1'b1, awready, 1'b1);
        tick();
        awvalid = 1'b0;
        chk("t5_aw_taken", awready === 1'b0, awready, 1'b0);
        wdata = 32'h00000011; wvalid = 1'b1; tick();
        wvalid = 1'b0;
        tick();
        chk("t5_second_b", bvalid === 1'b1, bvalid, 1'b1);
        chk("t5_second_wr", reg_wr === 8'h10, reg_wr, 8'h10);
        bready = 1'b1; tick(); bready = 1'b0;
        model[3] = 32'hA5A5A5A5;
        model[4] = 32'h00000011;
        chk("t5_regs", reg_out === model_flat(), reg_out, model_flat());

        axi_write(32'h43C00020, 32'hDEADBEEF, 4'hF, r, w);
`ifdef AXIL_REG_SLVERR_EN
        chk("t6_bresp_err", r === 2'b10, r, 2'b10);
        chk("t6_no_reg_wr", w === 8'h00, w, 8'h00);
        axi_read(32'h43C00020, d, r);
        chk("t6_rdata_zero", d === 32'h0, d, 32'h0);
        chk("t6_rresp_err", r === 2'b10, r, 2'b10);
`else
        chk("t6_bresp_alias", r === 2'b00, r, 2'b00);
        chk("t6_reg_wr_alias", w === 8'h01, w, 8'h01);
        model[0] = 32'hDEADBEEF;
        axi_read(32'h43C00020, d, r);
        chk("t6_rdata_alias", d === 32'hDEADBEEF, d, 32'hDEADBEEF);
        chk("t6_rresp_alias", r === 2'b00, r, 2'b00);
`endif
        chk("t6_regs", reg_out === model_flat(), reg_out, model_flat());

        araddr = 32'h43C00008; arvalid = 1'b1; rready = 1'b0; tick();
        arvalid = 1'b0;
        chk("t7_r_pending", rvalid === 1'b1, rvalid, 1'b1);
        wdata = 32'h00000077; wstrb = 4'hF; wvalid = 1'b1; tick();
        wvalid = 1'b0;
        chk("t7_w_held", wready === 1'b0, wready, 1'b0);
        awaddr = 32'h43C0000C; awvalid = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("t7_awready", awready === 1'b1, awready, 1'b1);
        chk("t7_wready", wready === 1'b1, wready, 1'b1);
        chk("t7_arready", arready === 1'b1, arready, 1'b1);
        chk("t7_bvalid", bvalid === 1'b0, bvalid, 1'b0);
        chk("t7_rvalid", rvalid === 1'b0, rvalid, 1'b0);
        chk("t7_rdata", rdata === 32'h0, rdata, 32'h0);
        chk("t7_bresp", bresp === 2'b00, bresp, 2'b00);
        chk("t7_reg_wr", reg_wr === 8'h00, reg_wr, 8'h00);
        chk("t7_regs", reg_out === 256'h0, reg_out, 256'h0);
        awvalid = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < N; k++) model[k] = 32'h0;
        tick();
        chk("t7_no_stale_b", bvalid === 1'b0, bvalid, 1'b0);
        axi_write(32'h43C00014, 32'hCAFEF00D, 4'hF, r, w);
        chk("t7_fresh_bresp", r === 2'b00, r, 2'b00);
        chk("t7_fresh_wr", w === 8'h20, w, 8'h20);
        model[5] = 32'hCAFEF00D;
        axi_read(32'h43C00014, d, r);
        chk("t7_fresh_rdata", d === 32'hCAFEF00D, d, 32'hCAFEF00D);
        chk("t7_final_regs", reg_out === model_flat(), reg_out, model_flat());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

Generic AXI4-Lite responder exposing a bank of 32-bit read/write registers to fabric logic. It is the subordinate end of the AXI4-Lite bus driven by the PS or by our bench write/read tasks. It is the common register front-end for display and GPIO-style peripherals. AW and W are accepted independently, in either order. Byte strobes, back-pressured responses and out-of-range error responses are supported.

## Interface
- C_NUM_REGS, 8: number of 32-bit registers; 2..64.
- C_S_AXI_ADDR_WIDTH, 32: width of awaddr/araddr.
- s_axi_aclk  in  1  sole clock; all logic on rising edge.
- s_axi_areset  in  1  reset, asynchronous assert, active-high; deassert synchronously to s_axi_aclk upstream.
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  as bresp.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- reg_out  out  32*C_NUM_REGS  flattened register contents; reg k at [32k+31:32k].
- reg_wr  out  C_NUM_REGS  one-cycle pulse, bit k, on the cycle register k is updated.

## Operation
- Register index is addr[2+IW-1:2], where IW = clog2(C_NUM_REGS). Bits [1:0] and bits above the index are ignored, so base 0x43C00000 maps index 0.
- Write path: an AW holding register and a W holding register, each with a valid flag.
  - awready = !aw_held && !bvalid.
  - wready = !w_held && !bvalid.
  - A handshake sets the corresponding flag and captures addr, or data and strobe.
- Commit occurs when both flags are set.
  - Only lanes with wstrb=1 are updated; other lanes keep their value.
  - reg_wr[k] pulses, bvalid is set, both flags clear.
- bvalid holds until a bready handshake. Response fields are stable while valid.
- Read path: arready = !rvalid.
  - On the AR handshake, rdata/rresp are registered from current register state and rvalid is set.
  - rvalid holds until a rready handshake.
- Read and write paths are independent and may be active in the same cycle.
- A read whose AR handshake lands on the write-commit edge returns the pre-write value.
- Reset: all registers 0, all flags 0. awready=1, wready=1, arready=1. bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, reg_wr=0.
- Reset mid-transaction discards any held AW/W and any pending B/R. No register update occurs.

## Timing
- Write latency: commit and bvalid rise on the first edge after the later of the AW/W handshakes. If both handshakes occur at the same edge, commit is on the next edge.
- reg_wr pulses in the cycle after commit, with reg_out already showing the new value.
- Minimum write period is 3 cycles with bready tied high: handshake, bvalid, ready again.
- Read latency: rvalid is high the cycle after the AR handshake.
- Back-to-back reads with rready=1 sustain 1 read per 2 cycles.
- W arriving before AW (the bench ordering): W is held with wready=0 until AW arrives. No deadlock in either order.
- A second AW or W is not accepted until the pending bvalid has handshaken.

## Configuration
- AXIL_REG_SLVERR_EN defined: index >= C_NUM_REGS is decoded with clog2(C_NUM_REGS)+1 index bits.
  - A write to such an index updates nothing, produces no reg_wr, and returns bresp=2'b10.
  - A read returns rdata=0 and rresp=2'b10.
  - The index decode is widened by one bit; for power-of-two C_NUM_REGS this is exactly the first word above the bank.
- AXIL_REG_SLVERR_EN undefined: the index is taken modulo C_NUM_REGS via the IW-bit decode. All responses are OKAY and addresses alias.

## Test plan
- W at edge N, AW at N+1, addr 0x43C00004, data 0x01020304, strb 0xF → reg 1 = 0x01020304, reg_wr[1] pulses, bvalid at N+2, bresp 0.
- AW then W two cycles later to reg 0, data 0x3 → wready stays 1 while waiting; commit one edge after W. A subsequent read of 0x43C00000 returns 0x00000003, rresp 0.
- Reg 2 = 0x05060708, then write 0xFFFFFFFF with strb 0x5 → readback 0x05FF07FF.
- Hold bready=0 for 5 cycles after a write → bvalid held, awready=wready=0 throughout; a new AW is accepted only after the B handshake.
- With AXIL_REG_SLVERR_EN and C_NUM_REGS=8, write and read 0x43C00020 → bresp=2'b10, rresp=2'b10, rdata 0, no reg_wr, registers unchanged.
- Assert s_axi_areset with W held and AW pending → all outputs at reset values asynchronously, registers 0. After release, a fresh write completes normally.
